rl_pair_dispatcher: RTL and testbench

RL_PAIR_DISPATCHER -- requirements
Module: rl_pair_dispatcher

---
 rtl/rl_pair_dispatcher.sv | 283 ++++++++++++++++++++++++++++
 tb/tb_rl_pair_dispatcher.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/rl_pair_dispatcher.sv
// Cell-pair particle sweep: walks i over the home cell and j over the neighbor cell,
// reading both 1-cycle caches and presenting registered pairs. Define RL_PAIR_DISPATCH_COUNTER_EN for pair_count.
module rl_pair_dispatcher #(
  parameter int DATA_WIDTH        = 32,
  parameter int CELL_ID_WIDTH     = 12,
  parameter int ADDR_WIDTH        = 8,
  parameter int PARTICLE_ID_WIDTH = CELL_ID_WIDTH + ADDR_WIDTH
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         start,
  input  logic [CELL_ID_WIDTH-1:0]     ref_cell_id,
  input  logic [CELL_ID_WIDTH-1:0]     nb_cell_id,
  input  logic [ADDR_WIDTH-1:0]        ref_count,
  input  logic [ADDR_WIDTH-1:0]        nb_count,
  output logic [ADDR_WIDTH-1:0]        ref_rd_addr,
  output logic [ADDR_WIDTH-1:0]        nb_rd_addr,
  input  logic [3*DATA_WIDTH-1:0]      ref_rd_data,
  input  logic [3*DATA_WIDTH-1:0]      nb_rd_data,
  input  logic                         back_pressure,
  output logic                         out_valid,
  output logic [PARTICLE_ID_WIDTH-1:0] ref_particle_id,
  output logic [PARTICLE_ID_WIDTH-1:0] neighbor_particle_id,
  output logic [DATA_WIDTH-1:0]        refx,
  output logic [DATA_WIDTH-1:0]        refy,
  output logic [DATA_WIDTH-1:0]        refz,
  output logic [DATA_WIDTH-1:0]        neighborx,
  output logic [DATA_WIDTH-1:0]        neighbory,
  output logic [DATA_WIDTH-1:0]        neighborz,
  output logic                         busy,
  output logic                         done,
  output logic [31:0]                  pair_count
);

  // state    | meaning
  // IDLE     | waiting for start
  // LOAD_REF | issuing the first read of a new ref particle i
  // RUN      | issuing remaining j reads of row i, then draining the pipeline
  // DONE     | one-cycle done pulse
  typedef enum logic [1:0] {IDLE, LOAD_REF, RUN, DONE} state_t;

  localparam int CRD_W = 3 * DATA_WIDTH;
  localparam int AW    = ADDR_WIDTH;

  state_t                   state_q, state_d;
  logic [CELL_ID_WIDTH-1:0] ref_cell_q, ref_cell_d, nb_cell_q, nb_cell_d;
  logic [AW-1:0]            ref_cnt_q, ref_cnt_d, nb_cnt_q, nb_cnt_d;
  logic                     same_q, same_d;
  logic [AW-1:0]            cur_i_q, cur_i_d, cur_j_q, cur_j_d;
  logic                     all_iss_q, all_iss_d;
  logic [AW-1:0]            ref_addr_q, ref_addr_d, nb_addr_q, nb_addr_d;
  // stage 1: address presented to caches; stage 2: data on cache outputs
  logic                     v1_q, v1_d, v2_q, v2_d;
  logic [AW-1:0]            i1_q, i1_d, j1_q, j1_d, i2_q, i2_d, j2_q, j2_d;
  logic                     sk_q, sk_d;
  logic [AW-1:0]            sk_i_q, sk_i_d, sk_j_q, sk_j_d;
  logic [CRD_W-1:0]         sk_rd_q, sk_rd_d, sk_nd_q, sk_nd_d;
  logic                     out_valid_q, out_valid_d;
  logic [PARTICLE_ID_WIDTH-1:0] rid_q, rid_d, nid_q, nid_d;
  logic [CRD_W-1:0]         rxyz_q, rxyz_d, nxyz_q, nxyz_d;
  logic                     busy_q, busy_d, done_q, done_d;

  logic                     take_sk, take_s2, v2_keep, issue_ok;
  logic                     same_in, empty_in, last_j, rows_done;
  logic [AW:0]              next_i;

  assign same_in  = (ref_cell_id == nb_cell_id);
  assign empty_in = (ref_count == '0) || (nb_count == '0) ||
                    (same_in && ((ref_count < AW'(2)) || (nb_count < AW'(2))));
  assign last_j    = (cur_j_q == nb_cnt_q - AW'(1));
  assign next_i    = {1'b0, cur_i_q} + (AW+1)'(1);
  assign rows_done = (next_i >= {1'b0, ref_cnt_q}) ||
                     (same_q && ((next_i + (AW+1)'(1)) >= {1'b0, nb_cnt_q}));
  assign take_sk   = !back_pressure && sk_q;
  assign take_s2   = !back_pressure && !sk_q && v2_q;

`ifdef RL_PAIR_DISPATCH_COUNTER_EN
  logic [31:0] pair_count_q, pair_count_d;
  assign pair_count = pair_count_q;
`else
  assign pair_count = '0;
`endif

  always_comb begin
    state_d     = state_q;
    ref_cell_d  = ref_cell_q;
    nb_cell_d   = nb_cell_q;
    ref_cnt_d   = ref_cnt_q;
    nb_cnt_d    = nb_cnt_q;
    same_d      = same_q;
    cur_i_d     = cur_i_q;
    cur_j_d     = cur_j_q;
    all_iss_d   = all_iss_q;
    ref_addr_d  = ref_addr_q;
    nb_addr_d   = nb_addr_q;
    v1_d        = 1'b0;
    i1_d        = i1_q;
    j1_d        = j1_q;
    i2_d        = i2_q;
    j2_d        = j2_q;
    sk_i_d      = sk_i_q;
    sk_j_d      = sk_j_q;
    sk_rd_d     = sk_rd_q;
    sk_nd_d     = sk_nd_q;
    rid_d       = rid_q;
    nid_d       = nid_q;
    rxyz_d      = rxyz_q;
    nxyz_d      = nxyz_q;
    out_valid_d = take_sk || take_s2;
    issue_ok    = 1'b0;
`ifdef RL_PAIR_DISPATCH_COUNTER_EN
    pair_count_d = pair_count_q;
`endif

    if (take_sk) begin
      rid_d  = PARTICLE_ID_WIDTH'({ref_cell_q, sk_i_q});
      nid_d  = PARTICLE_ID_WIDTH'({nb_cell_q, sk_j_q});
      rxyz_d = sk_rd_q;
      nxyz_d = sk_nd_q;
    end else if (take_s2) begin
      rid_d  = PARTICLE_ID_WIDTH'({ref_cell_q, i2_q});
      nid_d  = PARTICLE_ID_WIDTH'({nb_cell_q, j2_q});
      rxyz_d = ref_rd_data;
      nxyz_d = nb_rd_data;
    end

    // cache output is about to be replaced by stage 1 data: park stage 2 in the skid
    sk_d    = sk_q && !take_sk;
    v2_keep = v2_q && !take_s2;
    if (v1_q && v2_keep) begin
      sk_d    = 1'b1;
      sk_i_d  = i2_q;
      sk_j_d  = j2_q;
      sk_rd_d = ref_rd_data;
      sk_nd_d = nb_rd_data;
      v2_keep = 1'b0;
    end
    if (v1_q) begin
      v2_d = 1'b1;
      i2_d = i1_q;
      j2_d = j1_q;
    end else begin
      v2_d = v2_keep;
    end

    // a new read is only launched if a stall on the next edge could still be absorbed
    issue_ok = !back_pressure && !(sk_d && v2_d);

    case (state_q)
      IDLE: begin
        if (start) begin
          ref_cell_d = ref_cell_id;
          nb_cell_d  = nb_cell_id;
          ref_cnt_d  = ref_count;
          nb_cnt_d   = nb_count;
          same_d     = same_in;
          cur_i_d    = '0;
          cur_j_d    = same_in ? AW'(1) : '0;
          all_iss_d  = 1'b0;
          state_d    = empty_in ? DONE : LOAD_REF;
`ifdef RL_PAIR_DISPATCH_COUNTER_EN
          pair_count_d = '0;
`endif
        end
      end
      LOAD_REF, RUN: begin
        if (all_iss_q) begin
          if (!v1_q && !v2_q && !sk_q) state_d = DONE;
        end else if (issue_ok) begin
          ref_addr_d = cur_i_q;
          nb_addr_d  = cur_j_q;
          v1_d       = 1'b1;
          i1_d       = cur_i_q;
          j1_d       = cur_j_q;
          if (!last_j) begin
            cur_j_d = cur_j_q + AW'(1);
            state_d = RUN;
          end else if (rows_done) begin
            all_iss_d = 1'b1;
            state_d   = RUN;
          end else begin
            cur_i_d = next_i[AW-1:0];
            cur_j_d = same_q ? (next_i[AW-1:0] + AW'(1)) : '0;
            state_d = LOAD_REF;
          end
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    busy_d = (state_d != IDLE);
    done_d = (state_d == DONE);
`ifdef RL_PAIR_DISPATCH_COUNTER_EN
    if (out_valid_d && (pair_count_d != 32'hFFFF_FFFF)) pair_count_d = pair_count_d + 32'd1;
`endif
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      ref_cell_q  <= '0;
      nb_cell_q   <= '0;
      ref_cnt_q   <= '0;
      nb_cnt_q    <= '0;
      same_q      <= 1'b0;
      cur_i_q     <= '0;
      cur_j_q     <= '0;
      all_iss_q   <= 1'b0;
      ref_addr_q  <= '0;
      nb_addr_q   <= '0;
      v1_q        <= 1'b0;
      i1_q        <= '0;
      j1_q        <= '0;
      v2_q        <= 1'b0;
      i2_q        <= '0;
      j2_q        <= '0;
      sk_q        <= 1'b0;
      sk_i_q      <= '0;
      sk_j_q      <= '0;
      sk_rd_q     <= '0;
      sk_nd_q     <= '0;
      out_valid_q <= 1'b0;
      rid_q       <= '0;
      nid_q       <= '0;
      rxyz_q      <= '0;
      nxyz_q      <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
`ifdef RL_PAIR_DISPATCH_COUNTER_EN
      pair_count_q <= '0;
`endif
    end else begin
      state_q     <= state_d;
      ref_cell_q  <= ref_cell_d;
      nb_cell_q   <= nb_cell_d;
      ref_cnt_q   <= ref_cnt_d;
      nb_cnt_q    <= nb_cnt_d;
      same_q      <= same_d;
      cur_i_q     <= cur_i_d;
      cur_j_q     <= cur_j_d;
      all_iss_q   <= all_iss_d;
      ref_addr_q  <= ref_addr_d;
      nb_addr_q   <= nb_addr_d;
      v1_q        <= v1_d;
      i1_q        <= i1_d;
      j1_q        <= j1_d;
      v2_q        <= v2_d;
      i2_q        <= i2_d;
      j2_q        <= j2_d;
      sk_q        <= sk_d;
      sk_i_q      <= sk_i_d;
      sk_j_q      <= sk_j_d;
      sk_rd_q     <= sk_rd_d;
      sk_nd_q     <= sk_nd_d;
      out_valid_q <= out_valid_d;
      rid_q       <= rid_d;
      nid_q       <= nid_d;
      rxyz_q      <= rxyz_d;
      nxyz_q      <= nxyz_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
`ifdef RL_PAIR_DISPATCH_COUNTER_EN
      pair_count_q <= pair_count_d;
`endif
    end
  end

  assign ref_rd_addr          = ref_addr_q;
  assign nb_rd_addr           = nb_addr_q;
  assign out_valid            = out_valid_q;
  assign ref_particle_id      = rid_q;
  assign neighbor_particle_id = nid_q;
  assign refx                 = rxyz_q[DATA_WIDTH-1:0];
  assign refy                 = rxyz_q[2*DATA_WIDTH-1:DATA_WIDTH];
  assign refz                 = rxyz_q[3*DATA_WIDTH-1:2*DATA_WIDTH];
  assign neighborx            = nxyz_q[DATA_WIDTH-1:0];
  assign neighbory            = nxyz_q[2*DATA_WIDTH-1:DATA_WIDTH];
  assign neighborz            = nxyz_q[3*DATA_WIDTH-1:2*DATA_WIDTH];
  assign busy                 = busy_q;
  assign done                 = done_q;

endmodule

// File: tb/tb_rl_pair_dispatcher.sv
// Bench for rl_pair_dispatcher: table of sweeps plus randomized sweeps against a pair-list model.
module tb_rl_pair_dispatcher;
  logic        clk = 1'b0;
  logic        rst, start, back_pressure;
  logic [11:0] ref_cell_id, nb_cell_id;
  logic [7:0]  ref_count, nb_count;
  logic [7:0]  ref_rd_addr, nb_rd_addr;
  logic [95:0] ref_rd_data, nb_rd_data;
  logic        out_valid, busy, done;
  logic [19:0] ref_particle_id, neighbor_particle_id;
  logic [31:0] refx, refy, refz, neighborx, neighbory, neighborz, pair_count;

  always #5 clk = ~clk;

  rl_pair_dispatcher dut (
    .clk(clk), .rst(rst), .start(start),
    .ref_cell_id(ref_cell_id), .nb_cell_id(nb_cell_id),
    .ref_count(ref_count), .nb_count(nb_count),
    .ref_rd_addr(ref_rd_addr), .nb_rd_addr(nb_rd_addr),
    .ref_rd_data(ref_rd_data), .nb_rd_data(nb_rd_data),
    .back_pressure(back_pressure), .out_valid(out_valid),
    .ref_particle_id(ref_particle_id), .neighbor_particle_id(neighbor_particle_id),
    .refx(refx), .refy(refy), .refz(refz),
    .neighborx(neighborx), .neighbory(neighbory), .neighborz(neighborz),
    .busy(busy), .done(done), .pair_count(pair_count)
  );

  function automatic logic [31:0] coord(input logic [11:0] c, input logic [7:0] idx, input int a);
    return {4'(a + 1), c, idx, 8'hA5};
  endfunction

  function automatic logic [95:0] pack(input logic [11:0] c, input logic [7:0] idx);
    return {coord(c, idx, 2), coord(c, idx, 1), coord(c, idx, 0)};
  endfunction

  // cache models: registered read, data one cycle after the address
  logic [11:0] cur_rc = '0, cur_nc = '0;
  always @(posedge clk) begin
    ref_rd_data <= pack(cur_rc, ref_rd_addr);
    nb_rd_data  <= pack(cur_nc, nb_rd_addr);
  end

  int vectors = 0, miscompares = 0;

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [11:0] rc, nc;
    logic [7:0]  rcnt, ncnt;
    int          bp_mode;
    int          exp_pairs;
    int          abort_after;
    bit          dbl_start;
  } vec_t;

  logic [231:0] exp_q[$];

  task automatic build_expected(input vec_t v);
    bit same = (v.rc == v.nc);
    exp_q.delete();
    for (int i = 0; i < int'(v.rcnt); i++)
      for (int j = 0; j < int'(v.ncnt); j++)
        if (!same || j > i)
          exp_q.push_back({v.rc, 8'(i), v.nc, 8'(j), coord(v.rc, 8'(i), 0), coord(v.rc, 8'(i), 1),
                           coord(v.rc, 8'(i), 2), coord(v.nc, 8'(j), 0), coord(v.nc, 8'(j), 1),
                           coord(v.nc, 8'(j), 2)});
  endtask

  task automatic run_sweep(input vec_t v);
    int first_k = -1, last_k = -1, done_k = -1, done_cnt = 0, pairs = 0;
    bit bp_prev = 1'b0;
    logic [31:0] exp_pc;
    cur_rc = v.rc;
    cur_nc = v.nc;
    build_expected(v);
`ifdef RL_PAIR_DISPATCH_COUNTER_EN
    exp_pc = 32'(v.exp_pairs);
`else
    exp_pc = 32'd0;
`endif
    @(negedge clk);
    ref_cell_id = v.rc; nb_cell_id = v.nc; ref_count = v.rcnt; nb_count = v.ncnt;
    start = 1'b1; back_pressure = 1'b0;
    @(posedge clk);
    for (int cyc = 0; cyc < 600; cyc++) begin
      @(negedge clk);
      start = 1'b0;
      if (v.dbl_start && cyc == 3) begin
        start = 1'b1;
        ref_cell_id = v.rc + 12'd1; ref_count = 8'd2; nb_count = 8'd2;
      end
      if (bp_prev) check("bp_hold", 256'(out_valid), 256'd0);
      if (out_valid) begin
        pairs++;
        if (first_k < 0) first_k = cyc;
        last_k = cyc;
        if (exp_q.size() == 0) check("extra_pair", 256'd1, 256'd0);
        else check("pair", {ref_particle_id, neighbor_particle_id, refx, refy, refz,
                            neighborx, neighbory, neighborz}, 256'(exp_q.pop_front()));
        if (v.abort_after > 0 && pairs == v.abort_after) begin
          rst = 1'b0;
          #1;
          check("rst_zero", {out_valid, busy, done, ref_particle_id, neighbor_particle_id, refx, refy,
                             refz, neighborx, neighbory, neighborz, ref_rd_addr, nb_rd_addr, pair_count},
                256'd0);
          back_pressure = 1'b0;
          start = 1'b0;
          repeat (2) begin
            @(negedge clk);
            check("rst_quiet", {out_valid, busy}, 256'd0);
          end
          rst = 1'b1;
          return;
        end
      end
      if (done) begin
        done_cnt++;
        if (done_k < 0) done_k = cyc;
        check("pair_count", 256'(pair_count), 256'(exp_pc));
      end
      if (done_k >= 0 && cyc >= done_k + 3) break;
      case (v.bp_mode)
        1:       back_pressure = (cyc + 1 >= 5) && (cyc + 1 <= 9);
        2:       back_pressure = ($urandom_range(0, 2) == 0);
        default: back_pressure = 1'b0;
      endcase
      bp_prev = back_pressure;
    end
    back_pressure = 1'b0;
    if (done_k < 0) check("done_timeout", 256'd0, 256'd1);
    check("pair_total", 256'(pairs), 256'(v.exp_pairs));
    check("done_pulses", 256'(done_cnt), 256'd1);
    check("busy_idle", 256'(busy), 256'd0);
    if (v.exp_pairs == 0) check("empty_done_lat", 256'(done_k), 256'd0);
    if (v.bp_mode == 0 && v.exp_pairs > 0) begin
      check("first_lat", 256'(first_k), 256'd3);
      check("contiguous", 256'(last_k - first_k + 1), 256'(v.exp_pairs));
    end
  endtask

  vec_t tbl[11];

  initial begin
    tbl[0]  = '{12'd5,  12'd6,  8'd3, 8'd4, 0, 12, 0, 1'b0};
    tbl[1]  = '{12'd7,  12'd7,  8'd4, 8'd4, 0, 6,  0, 1'b0};
    tbl[2]  = '{12'd5,  12'd6,  8'd3, 8'd4, 1, 12, 0, 1'b0};
    tbl[3]  = '{12'd5,  12'd6,  8'd0, 8'd4, 0, 0,  0, 1'b0};
    tbl[4]  = '{12'd9,  12'd9,  8'd1, 8'd1, 0, 0,  0, 1'b0};
    tbl[5]  = '{12'd5,  12'd6,  8'd3, 8'd4, 0, 12, 5, 1'b0};
    tbl[6]  = '{12'd5,  12'd6,  8'd3, 8'd4, 0, 12, 0, 1'b0};
    tbl[7]  = '{12'd5,  12'd6,  8'd3, 8'd4, 0, 12, 0, 1'b1};
    tbl[8]  = '{12'd3,  12'd4,  8'd1, 8'd1, 0, 1,  0, 1'b0};
    tbl[9]  = '{12'd10, 12'd10, 8'd2, 8'd2, 0, 1,  0, 1'b0};
    tbl[10] = '{12'd1,  12'd2,  8'd4, 8'd0, 0, 0,  0, 1'b0};

    rst = 1'b0; start = 1'b0; back_pressure = 1'b0;
    ref_cell_id = '0; nb_cell_id = '0; ref_count = '0; nb_count = '0;
    repeat (3) @(negedge clk);
    check("reset_state", {out_valid, busy, done, ref_particle_id, neighbor_particle_id, refx, refy,
                          refz, neighborx, neighbory, neighborz, ref_rd_addr, nb_rd_addr, pair_count},
          256'd0);
    rst = 1'b1;
    repeat (2) @(negedge clk);

    for (int t = 0; t < 11; t++) run_sweep(tbl[t]);

    for (int r = 0; r < 16; r++) begin
      vec_t v;
      bit same = ($urandom_range(0, 2) == 0);
      v.rc   = 12'($urandom_range(0, 4095));
      v.nc   = same ? v.rc : (v.rc ^ 12'($urandom_range(1, 255)));
      v.rcnt = 8'($urandom_range(0, 6));
      v.ncnt = same ? v.rcnt : 8'($urandom_range(0, 6));
      v.exp_pairs = same ? (int'(v.rcnt) * (int'(v.rcnt) - 1)) / 2 : int'(v.rcnt) * int'(v.ncnt);
      v.bp_mode = 2;
      v.abort_after = 0;
      v.dbl_start = 1'b0;
      run_sweep(v);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
